// File: rtl/noop_pkg.sv
// Shared definitions for the NOP run monitor: FSM encoding and default NOP decode constants.
package noop_pkg;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HALT   = 2'd1;
  localparam logic [1:0] ST_RESUME = 2'd2;

  typedef enum logic [1:0] {
    RUN    = ST_RUN,
    HALT   = ST_HALT,
    RESUME = ST_RESUME
  } state_t;

  // Wide enough for any practical IR width; the top slices what it needs.
  localparam logic [63:0] DEF_NOP_VALUE = 64'h0;
  localparam logic [63:0] DEF_NOP_MASK  = '1;

endpackage

// File: rtl/noop_run_monitor_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/noop_run_monitor.sv
// Registered NOP decode with consecutive-run counting; halts intake after HALT_RUN NOPs in a row.
module noop_run_monitor
  import noop_pkg::*;
#(
  parameter int              IR_W      = 16,
  parameter logic [IR_W-1:0] NOP_VALUE = DEF_NOP_VALUE[IR_W-1:0],
  parameter logic [IR_W-1:0] NOP_MASK  = DEF_NOP_MASK[IR_W-1:0],
  parameter int              HALT_RUN  = 4,
  parameter int              RUN_W     = 4,
  parameter int              TOT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ir_valid,
  input  logic [IR_W-1:0]  IR,
  output logic             ir_ready,
  input  logic             halt_clear,
  output logic             noOp,
  output logic [RUN_W-1:0] run_cnt,
  output logic             halt,
  output logic [TOT_W-1:0] nop_total
);

  localparam logic [RUN_W:0] HALT_TGT = HALT_RUN[RUN_W:0];

  state_t         state, state_nxt;
  logic           is_nop;
  logic           accept;
  logic           nop_acc;
  logic           leave_halt;
  logic [RUN_W:0] run_inc;

  assign is_nop = ((IR & NOP_MASK) == (NOP_VALUE & NOP_MASK));

  assign ir_ready   = (state == RUN);
  assign halt       = (state == HALT);
  assign accept     = ir_valid && ir_ready;
  assign nop_acc    = accept && is_nop;
  assign leave_halt = (state == HALT) && halt_clear;
  // One bit wider so the halt compare cannot alias on wrap.
  assign run_inc    = {1'b0, run_cnt} + (RUN_W+1)'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (nop_acc && (run_inc == HALT_TGT)) state_nxt = HALT;
      HALT:    if (halt_clear) state_nxt = RESUME;
      RESUME:  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      noOp  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) noOp <= is_nop;
    end
  end

  sat_counter #(.W(RUN_W)) u_run_cnt (
    .clk (clk),
    .clr (rst || leave_halt || (accept && !is_nop)),
    .inc (nop_acc),
    .cnt (run_cnt)
  );

  sat_counter #(.W(TOT_W)) u_nop_total (
    .clk (clk),
    .clr (rst),
    .inc (nop_acc),
    .cnt (nop_total)
  );

endmodule

// File: tb/tb_noop_run_monitor.sv
// Directed bench: default, masked, narrow-total and HALT_RUN=1 monitors share one stimulus bus.
module tb_noop_run_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ir_valid = 1'b0;
  logic [15:0] IR = 16'h0;
  logic        halt_clear = 1'b0;

  logic        d_rdy, d_nop, d_halt;
  logic [3:0]  d_run;
  logic [15:0] d_tot;
  logic        m_rdy, m_nop, m_halt;
  logic [3:0]  m_run;
  logic [15:0] m_tot;
  logic        s_rdy, s_nop, s_halt;
  logic [3:0]  s_run;
  logic [1:0]  s_tot;
  logic        h_rdy, h_nop, h_halt;
  logic [3:0]  h_run;
  logic [15:0] h_tot;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  noop_run_monitor u_dflt (
    .clk(clk), .rst(rst), .ir_valid(ir_valid), .IR(IR), .ir_ready(d_rdy),
    .halt_clear(halt_clear), .noOp(d_nop), .run_cnt(d_run), .halt(d_halt), .nop_total(d_tot)
  );

  noop_run_monitor #(.NOP_MASK(16'hF000), .NOP_VALUE(16'h0)) u_mask (
    .clk(clk), .rst(rst), .ir_valid(ir_valid), .IR(IR), .ir_ready(m_rdy),
    .halt_clear(halt_clear), .noOp(m_nop), .run_cnt(m_run), .halt(m_halt), .nop_total(m_tot)
  );

  noop_run_monitor #(.TOT_W(2)) u_sat (
    .clk(clk), .rst(rst), .ir_valid(ir_valid), .IR(IR), .ir_ready(s_rdy),
    .halt_clear(halt_clear), .noOp(s_nop), .run_cnt(s_run), .halt(s_halt), .nop_total(s_tot)
  );

  noop_run_monitor #(.HALT_RUN(1)) u_h1 (
    .clk(clk), .rst(rst), .ir_valid(ir_valid), .IR(IR), .ir_ready(h_rdy),
    .halt_clear(halt_clear), .noOp(h_nop), .run_cnt(h_run), .halt(h_halt), .nop_total(h_tot)
  );

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ir_valid = 1'b0; halt_clear = 1'b0; IR = 16'h0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ir_valid = 1'b1; IR = 16'h0; halt_clear = 1'b0;
    step(); step();
    rst = 1'b0; ir_valid = 1'b0;
    total++;
    if ({d_nop, d_run, d_halt, d_tot} !== 22'h0)
      $display("FAIL reset_outputs got nop=%0b run=%0d halt=%0b tot=%0d want all 0", d_nop, d_run, d_halt, d_tot);
    else pass_cnt++;
    total++;
    if (d_rdy !== 1'b1) $display("FAIL reset_ready got %0b want 1", d_rdy);
    else pass_cnt++;
    step();
    total++;
    if (d_rdy !== 1'b1 || d_run !== 4'd0) $display("FAIL reset_after got rdy=%0b run=%0d want 1/0", d_rdy, d_run);
    else pass_cnt++;
  endtask

  task automatic test_halt_run();
    do_reset();
    ir_valid = 1'b1; IR = 16'h0;
    for (int i = 1; i <= 4; i++) begin
      step();
      total++;
      if (d_run !== 4'(i) || d_tot !== 16'(i))
        $display("FAIL halt_run_cnt[%0d] got run=%0d tot=%0d want %0d", i, d_run, d_tot, i);
      else pass_cnt++;
      total++;
      if (d_halt !== (i == 4) || d_rdy !== (i != 4))
        $display("FAIL halt_run_halt[%0d] got halt=%0b rdy=%0b want %0b/%0b", i, d_halt, d_rdy, i == 4, i != 4);
      else pass_cnt++;
      if (i == 1) begin
        total++;
        if (h_halt !== 1'b1 || h_rdy !== 1'b0 || h_run !== 4'd1)
          $display("FAIL halt_run1 got halt=%0b rdy=%0b run=%0d want 1/0/1", h_halt, h_rdy, h_run);
        else pass_cnt++;
      end
    end
    // Still valid NOPs while halted: must be ignored.
    step(); step();
    total++;
    if (d_run !== 4'd4 || d_tot !== 16'd4 || d_halt !== 1'b1 || d_nop !== 1'b1)
      $display("FAIL halt_hold got run=%0d tot=%0d halt=%0b nop=%0b want 4/4/1/1", d_run, d_tot, d_halt, d_nop);
    else pass_cnt++;
    ir_valid = 1'b0;
  endtask

  task automatic test_resume();
    halt_clear = 1'b1;
    step();
    halt_clear = 1'b0;
    total++;
    if (d_halt !== 1'b0 || d_run !== 4'd0 || d_rdy !== 1'b0 || d_tot !== 16'd4 || d_nop !== 1'b1)
      $display("FAIL resume_bubble got halt=%0b run=%0d rdy=%0b tot=%0d nop=%0b want 0/0/0/4/1",
               d_halt, d_run, d_rdy, d_tot, d_nop);
    else pass_cnt++;
    step();
    total++;
    if (d_rdy !== 1'b1 || d_halt !== 1'b0) $display("FAIL resume_run got rdy=%0b halt=%0b want 1/0", d_rdy, d_halt);
    else pass_cnt++;
    // Build a partial run, then pulse halt_clear in RUN: run must survive.
    ir_valid = 1'b1; IR = 16'h0;
    step();
    ir_valid = 1'b0; halt_clear = 1'b1;
    step();
    halt_clear = 1'b0;
    step();
    total++;
    if (d_rdy !== 1'b1 || d_halt !== 1'b0 || d_run !== 4'd1 || d_tot !== 16'd5)
      $display("FAIL clear_in_run got rdy=%0b halt=%0b run=%0d tot=%0d want 1/0/1/5", d_rdy, d_halt, d_run, d_tot);
    else pass_cnt++;
  endtask

  task automatic test_break_run();
    logic [15:0] irs  [4] = '{16'h0, 16'h0, 16'h1234, 16'h0};
    logic [3:0]  runs [4] = '{4'd1, 4'd2, 4'd0, 4'd1};
    logic        nops [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    ir_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IR = irs[i];
      step();
      total++;
      if (d_run !== runs[i] || d_nop !== nops[i] || d_halt !== 1'b0)
        $display("FAIL break_run[%0d] got run=%0d nop=%0b halt=%0b want %0d/%0b/0", i, d_run, d_nop, d_halt, runs[i], nops[i]);
      else pass_cnt++;
    end
    ir_valid = 1'b0; IR = 16'h0;
    total++;
    if (d_tot !== 16'd3) $display("FAIL break_total got %0d want 3", d_tot);
    else pass_cnt++;
  endtask

  task automatic test_gaps_mask();
    logic [3:0] runs [7] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4};
    do_reset();
    IR = 16'h0ABC;
    for (int i = 0; i < 7; i++) begin
      ir_valid = (i % 2 == 0);
      step();
      total++;
      if (m_run !== runs[i] || m_halt !== (i == 6))
        $display("FAIL gap_mask[%0d] got run=%0d halt=%0b want %0d/%0b", i, m_run, m_halt, runs[i], i == 6);
      else pass_cnt++;
    end
    ir_valid = 1'b0;
    total++;
    if (d_run !== 4'd0 || d_nop !== 1'b0 || d_tot !== 16'd0 || m_tot !== 16'd4)
      $display("FAIL mask_full_compare got dflt run=%0d nop=%0b tot=%0d mask tot=%0d want 0/0/0/4",
               d_run, d_nop, d_tot, m_tot);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    do_reset();
    ir_valid = 1'b1; IR = 16'h0;
    for (int i = 0; i < 4; i++) step();
    ir_valid = 1'b0;
    total++;
    if (s_tot !== 2'd3 || s_halt !== 1'b1) $display("FAIL sat_first got tot=%0d halt=%0b want 3/1", s_tot, s_halt);
    else pass_cnt++;
    halt_clear = 1'b1;
    step();
    halt_clear = 1'b0;
    step();
    ir_valid = 1'b1;
    step();
    ir_valid = 1'b0;
    total++;
    if (s_tot !== 2'd3 || s_run !== 4'd1 || d_tot !== 16'd5)
      $display("FAIL sat_stick got tot=%0d run=%0d dflt_tot=%0d want 3/1/5", s_tot, s_run, d_tot);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_halt();
    do_reset();
    ir_valid = 1'b1; IR = 16'h0;
    for (int i = 0; i < 4; i++) step();
    total++;
    if (d_halt !== 1'b1) $display("FAIL pre_reset_halt got %0b want 1", d_halt);
    else pass_cnt++;
    rst = 1'b1; halt_clear = 1'b1;
    step();
    rst = 1'b0; halt_clear = 1'b0; ir_valid = 1'b0;
    total++;
    if (d_halt !== 1'b0 || d_rdy !== 1'b1 || d_run !== 4'd0 || d_tot !== 16'd0 || d_nop !== 1'b0)
      $display("FAIL reset_mid_halt got halt=%0b rdy=%0b run=%0d tot=%0d nop=%0b want 0/1/0/0/0",
               d_halt, d_rdy, d_run, d_tot, d_nop);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_halt_run();
    test_resume();
    test_break_run();
    test_gaps_mask();
    test_saturation();
    test_reset_mid_halt();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
